// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin pick; a tie goes to the port that did not win last.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = a_req | b_req;
    if (a_req && b_req) begin
      grant_idx = ~last_grant;
    end else if (b_req) begin
      grant_idx = PORT_B;
    end else begin
      grant_idx = PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer for the dual-SRAM front end.
// Every output is registered; a watchdog bounds each access to TIMEOUT wait cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en_n,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t             state_q, state_d;
  logic               last_grant;
  logic               cmd_idx;
  logic               cmd_we;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [CNT_W-1:0]   cnt;
  logic               grant_valid, grant_idx;
  logic               latch, issue, cnt_inc, done_ok, done_to;

  ram_arb_rr u_rr (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    issue   = 1'b0;
    cnt_inc = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          latch   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the same cycle as the watchdog expiry still counts as success.
        if (mem_done) begin
          done_ok = 1'b1;
          state_d = ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          done_to = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_B;
      cmd_idx    <= PORT_A;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cnt        <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      rdata      <= '0;
      mem_en_n   <= 1'b1;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;
      if (latch) begin
        cmd_idx    <= grant_idx;
        last_grant <= grant_idx;
        if (grant_idx == PORT_B) begin
          cmd_we    <= b_we;
          cmd_addr  <= b_addr;
          cmd_wdata <= b_wdata;
        end else begin
          cmd_we    <= a_we;
          cmd_addr  <= a_addr;
          cmd_wdata <= a_wdata;
        end
      end
      if (issue) begin
        mem_en_n  <= 1'b0;
        mem_re    <= ~cmd_we;
        mem_we    <= cmd_we;
        mem_addr  <= cmd_addr;
        mem_wdata <= cmd_wdata;
        cnt       <= '0;
      end
      if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (done_ok || done_to) begin
        mem_en_n <= 1'b1;
        mem_re   <= 1'b0;
        mem_we   <= 1'b0;
        if (!cmd_we) rdata <= done_ok ? mem_rdata : '0;
        if (cmd_idx == PORT_B) begin
          b_ack <= 1'b1;
          b_err <= done_to;
        end else begin
          a_ack <= 1'b1;
          a_err <= done_to;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table plus hand-written contention, reset and withdrawal sequences.
module tb_ram_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [16:0] addr;
    logic [15:0] wdata;
    int          k;
    logic [15:0] mrd;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
    int          ack_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [16:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, a_err, b_ack, b_err;
  logic [15:0] rdata;
  logic        mem_en_n, mem_re, mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;

  int   compared = 0;
  int   failed = 0;
  int   cyc = 0;
  int   resp_k = 255;
  int   wcnt = 0;
  logic [15:0] resp_data = '0;
  logic mem_chk = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[9];

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err),
    .rdata(rdata), .mem_en_n(mem_en_n), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Front-end model: raises mem_done resp_k cycles after the enable is first seen low.
  always @(negedge clk) begin
    if (!mem_en_n) begin
      mem_done  = (wcnt == resp_k);
      mem_rdata = resp_data;
      wcnt++;
    end else begin
      mem_done = 1'b0;
      wcnt     = 0;
    end
  end

  // Scoreboard: checks the issued command and pops an expectation on every ack.
  always @(negedge clk) begin
    if (rst) begin
      if (!mem_en_n && exp_q.size() > 0 && !mem_chk) begin
        mem_chk = 1'b1;
        chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        chk("mem_strobes", {30'd0, mem_re, mem_we}, {30'd0, ~exp_q[0].we, exp_q[0].we});
        chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].wdata));
      end
      if (a_ack || b_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, a_ack, b_ack}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mem_chk = 1'b0;
          chk("ack_port", {30'd0, a_ack, b_ack}, mon_e.port ? 32'd1 : 32'd2);
          chk("ack_err", {30'd0, a_err, b_err}, mon_e.port ? {31'd0, mon_e.err} : {30'd0, mon_e.err, 1'b0});
          chk("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("ack_en_n", 32'(mem_en_n), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_size(input int target, input int budget);
    for (int i = 0; i < budget && exp_q.size() > target; i++) step();
    chk("wait_bound", exp_q.size(), target);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    resp_k    = v.k;
    resp_data = v.mrd;
    e = '{port: v.port, we: v.we, addr: v.addr, wdata: v.wdata,
          err: v.exp_err, rdata: v.exp_rdata, ack_cyc: cyc + v.exp_lat};
    exp_q.push_back(e);
    if (v.port) begin
      b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1;
    end else begin
      a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1;
    end
    wait_size(0, 40);
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    chk("rdata_hold", 32'(rdata), 32'(v.exp_rdata));
  endtask

  // Both ports held: A (read) and B (write) alternate for the given number of rounds.
  task automatic contend(input int rounds);
    exp_t e;
    int   c;
    c = cyc;
    resp_k = 0;
    resp_data = 16'h3C3C;
    a_we = 1'b0; a_addr = 17'h00100; a_wdata = 16'h0000;
    b_we = 1'b1; b_addr = 17'h10200; b_wdata = 16'h5555;
    for (int r = 0; r < rounds; r++) begin
      e = '{port: 1'b0, we: 1'b0, addr: 17'h00100, wdata: 16'h0000, err: 1'b0, rdata: 16'h3C3C, ack_cyc: c + 3 + 8 * r};
      exp_q.push_back(e);
      e = '{port: 1'b1, we: 1'b1, addr: 17'h10200, wdata: 16'h5555, err: 1'b0, rdata: 16'h3C3C, ack_cyc: c + 7 + 8 * r};
      exp_q.push_back(e);
    end
    a_req = 1'b1;
    b_req = 1'b1;
    wait_size(1, 16 * rounds);
    a_req = 1'b0;
    wait_size(0, 16);
    b_req = 1'b0;
    step();
  endtask

  initial begin
    exp_t e;
    int   c;
    //          port  we    addr       wdata     k    mrd       err   rdata     lat
    vecs[0] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 2,   16'h1234, 1'b0, 16'h1234, 5};
    vecs[1] = '{1'b1, 1'b1, 17'h10005, 16'hBEEF, 0,   16'h0000, 1'b0, 16'h1234, 3};
    vecs[2] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, 0,   16'hA5A5, 1'b0, 16'hA5A5, 3};
    vecs[3] = '{1'b1, 1'b0, 17'h00000, 16'h0000, 5,   16'h0F0F, 1'b0, 16'h0F0F, 8};
    vecs[4] = '{1'b0, 1'b1, 17'h00001, 16'h1111, 255, 16'h0000, 1'b1, 16'h0F0F, 18};
    vecs[5] = '{1'b0, 1'b0, 17'h00020, 16'h0000, 255, 16'h9999, 1'b1, 16'h0000, 18};
    vecs[6] = '{1'b1, 1'b0, 17'h10000, 16'h0000, 14,  16'hCAFE, 1'b0, 16'hCAFE, 17};
    vecs[7] = '{1'b0, 1'b0, 17'h00030, 16'h0000, 1,   16'h7777, 1'b0, 16'h7777, 4};
    vecs[8] = '{1'b1, 1'b1, 17'h1FFFE, 16'h0000, 3,   16'h0000, 1'b0, 16'h7777, 6};

    repeat (3) step();
    chk("rst_en_n", 32'(mem_en_n), 32'd1);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;
    step();

    contend(2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a stalled read.
    resp_k = 255;
    a_we = 1'b0; a_addr = 17'h00044; a_wdata = 16'h0000;
    e = '{port: 1'b0, we: 1'b0, addr: 17'h00044, wdata: 16'h0000, err: 1'b0, rdata: 16'h0000, ack_cyc: 0};
    exp_q.push_back(e);
    a_req = 1'b1;
    repeat (5) step();
    chk("pre_rst_en_n", 32'(mem_en_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_en_n", 32'(mem_en_n), 32'd1);
    chk("async_rst_re", 32'(mem_re), 32'd0);
    chk("async_rst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    chk("async_rst_rdata", 32'(rdata), 32'd0);
    exp_q.delete();
    mem_chk = 1'b0;
    a_req = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    contend(1);

    // B withdraws its request during ISSUE and scribbles its address.
    resp_k = 1;
    resp_data = 16'h4242;
    c = cyc;
    b_we = 1'b0; b_addr = 17'h1ABCD; b_wdata = 16'h0000;
    e = '{port: 1'b1, we: 1'b0, addr: 17'h1ABCD, wdata: 16'h0000, err: 1'b0, rdata: 16'h4242, ack_cyc: c + 4};
    exp_q.push_back(e);
    b_req = 1'b1;
    step();
    b_req = 1'b0;
    b_addr = 17'h00BAD;
    wait_size(0, 20);
    repeat (8) step();
    chk("idle_en_n", 32'(mem_en_n), 32'd1);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
